// File: rtl/uart_core.sv
// uart_core: parametrised UART transceiver (TX FIFO + TX serialiser, RX
// deserialiser + single-entry holding register).
//
// Parameters:
//   CLK_HZ, BAUD  -> CLKS_PER_BIT = CLK_HZ/BAUD (truncated, >= 4)
//   DATA_W        -> data bits per frame (5..8)
//   FIFO_DEPTH    -> TX FIFO entries (power of two, >= 2)
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready  FIFO push handshake
//   tx_busy                    FIFO non-empty or frame on the line
//   rx_data/rx_valid/rx_ready  received byte handshake
//   rx_frame_err, rx_parity_err, rx_overrun   one-cycle fault pulses
//   uart_rx, uart_tx           serial pins (uart_tx registered, idles high)
//
// Build option: define UART_PARITY_EN to add an even-parity bit after the
// data bits on TX and check it on RX. Without it rx_parity_err is tied low.
module uart_core #(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun,
  input  logic              uart_rx,
  output logic              uart_tx
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [AW:0]      CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic              push, pop;

  assign tx_ready = (fifo_cnt != CNT_FULL);
  assign push     = tx_valid && tx_ready;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shreg;
  logic              tx_line_d;
  logic              tx_cnt_end;
  logic              tx_active_q;

  assign tx_cnt_end = (tx_cnt_q == CNT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_line_d  = 1'b1;
    pop        = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (fifo_cnt != '0) begin
          pop        = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        if (tx_cnt_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_line_d = tx_shreg[tx_bit_q];
        if (tx_cnt_end) begin
          if (tx_bit_q == BIT_LAST) begin
            tx_bit_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_line_d = ^tx_shreg;
        if (tx_cnt_end) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (tx_cnt_end) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // uart_tx is the registered image of the current state, so the line lags
  // the FSM by one cycle; tx_active_q tracks that lag so tx_busy covers the
  // full stop bit as seen on the pin.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      uart_tx     <= 1'b1;
      tx_active_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      uart_tx     <= tx_line_d;
      tx_active_q <= (tx_state_q != TX_IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (pop) tx_shreg <= fifo_mem[rd_ptr];
  end

  assign tx_busy = (fifo_cnt != '0) || (tx_state_q != TX_IDLE) || tx_active_q;

  // ---------------- RX synchroniser (p0 -> p1), plus edge history ----------------
  logic rx_sync_p0, rx_sync_p1, rx_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shreg;
  logic              rx_shift, rx_done, rx_cnt_end;
  logic              frame_bad, parity_bad, rx_good;
`ifdef UART_PARITY_EN
  logic              rx_par_ld, rx_par_q;
`endif

  assign rx_cnt_end = (rx_cnt_q == CNT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift   = 1'b0;
    rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_ld  = 1'b0;
`endif
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_end ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync_p1) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid start bit: re-centre the counter so later samples land mid-bit.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_p1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_shift = 1'b1;
          if (rx_bit_q == BIT_LAST) begin
            rx_bit_d = '0;
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_end) begin
          rx_par_ld  = 1'b1;
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_end) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge CLK) begin
    if (rx_shift) rx_shreg <= {rx_sync_p1, rx_shreg[DATA_W-1:1]};
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge CLK) begin
    if (rx_par_ld) rx_par_q <= rx_sync_p1;
  end
  assign parity_bad = rx_done && (rx_par_q != ^rx_shreg);
`else
  assign parity_bad = 1'b0;
`endif

  assign frame_bad = rx_done && !rx_sync_p1;
  assign rx_good   = rx_done && !frame_bad && !parity_bad;

  // ---------------- RX holding register and fault pulses ----------------
  logic rx_perr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      rx_perr_q    <= parity_bad;
      rx_overrun   <= 1'b0;
      if (rx_good) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_parity_err = rx_perr_q;

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;
  localparam int CLK_HZ = 16000000;
  localparam int BAUD   = 1000000;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = DW + 2 + P;
  localparam int FRAME = NBITS * CPB;
  localparam int DRAIN_MAX = 6000;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic       ov;
    logic       take;
    logic [7:0] data;
  } ev_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_busy;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          rx_frame_err, rx_parity_err, rx_overrun;
  logic          uart_rx, uart_tx;
  logic          loop = 1'b0;
  logic          drv_rx = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] tx_exp[$];
  ev_t        rx_exp[$];
  int         tx_starts[$];
  bit         hold_full = 0;
  logic [7:0] hold_data = '0;

  assign uart_rx = loop ? uart_tx : drv_rx;

  uart_core #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference line image of one frame, bit 0 first on the wire.
  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1 + i] = d[i];
    n = 1 + DW;
    if (P == 1) begin
      f[n] = ^d[DW-1:0];
      n++;
    end
    f[n] = 1'b1;
    for (int i = n + 1; i < 16; i++) f[i] = 1'b0;
    return f;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    ev_t e;
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin
      hold(1);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL push_wait: tx_ready stuck low, got %b expected 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    tx_exp.push_back(d);
    if (loop) begin
      e = '0;
      e.take = 1'b1;
      e.data = d;
      rx_exp.push_back(e);
    end
    hold(1);
    tx_valid = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] d, input bit pflip, input bit stop);
    ev_t e;
    bit fe, pe;
    fe = !stop;
    pe = (P == 1) && pflip;
    e = '0;
    if (fe || pe) begin
      e.fe = fe;
      e.pe = pe;
      rx_exp.push_back(e);
    end else if (rx_ready) begin
      e.take = 1'b1;
      e.data = d;
      rx_exp.push_back(e);
    end else if (hold_full) begin
      e.ov = 1'b1;
      rx_exp.push_back(e);
    end else begin
      hold_full = 1;
      hold_data = d;
    end
    drv_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < DW; i++) begin
      drv_rx = d[i];
      hold(CPB);
    end
    if (P == 1) begin
      drv_rx = (^d) ^ pflip;
      hold(CPB);
    end
    drv_rx = stop;
    hold(CPB);
    drv_rx = 1'b1;
    hold(2 * CPB);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0 || tx_busy !== 1'b0) && n < DRAIN_MAX) begin
      hold(1);
      n++;
    end
    hold(2 * CPB);
    check({name, "_drained"}, tx_exp.size() + rx_exp.size(), 0);
    check({name, "_idle"}, {31'd0, tx_busy}, 0);
  endtask

  // TX monitor: decode frames off the pin mid-bit and score them.
  initial begin : tx_mon
    logic [15:0] got;
    logic [7:0]  d;
    int          sc;
    bit          aborted;
    wait (RST_N === 1'b1);
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && uart_tx === 1'b0) begin
        sc = cyc;
        aborted = 0;
        got = '0;
        for (int b = 0; b < NBITS; b++) begin
          repeat ((b == 0) ? CPB / 2 : CPB) begin
            @(negedge CLK);
            if (RST_N !== 1'b1) aborted = 1;
          end
          got[b] = uart_tx;
        end
        if (!aborted) begin
          tx_starts.push_back(sc);
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame: got bits 0x%0h expected no frame", got);
          end else begin
            d = tx_exp.pop_front();
            check("tx_frame", {16'd0, got}, {16'd0, frame_bits(d)});
          end
        end
      end
    end
  end

  // RX monitor: every pulse or consumed byte is one event against the queue.
  initial begin : rx_mon
    ev_t a, e;
    wait (RST_N === 1'b1);
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && (rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0 ||
          rx_overrun !== 1'b0 || (rx_valid === 1'b1 && rx_ready === 1'b1))) begin
        a = '0;
        a.fe = rx_frame_err;
        a.pe = rx_parity_err;
        a.ov = rx_overrun;
        a.take = rx_valid && rx_ready;
        if (a.take) a.data = rx_data;
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_event: got 0x%0h expected none", a);
        end else begin
          e = rx_exp.pop_front();
          check("rx_event", {20'd0, a}, {20'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #(80000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lows;
    logic [7:0] r;
    // Reset state
    hold(3);
    check("rst_uart_tx", {31'd0, uart_tx}, 1);
    check("rst_tx_ready", {31'd0, tx_ready}, 1);
    check("rst_tx_busy", {31'd0, tx_busy}, 0);
    check("rst_rx_valid", {31'd0, rx_valid}, 0);
    check("rst_rx_data", {24'd0, rx_data}, 0);
    check("rst_err_pulses", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 0);
    RST_N = 1'b1;
    hold(2);
    check("post_rst_uart_tx", {31'd0, uart_tx}, 1);

    // Single frame 0xA5: latency and busy window
    push(8'hA5);
    check("a5_busy_after_push", {31'd0, tx_busy}, 1);
    check("a5_lat_e0", {31'd0, uart_tx}, 1);
    hold(1);
    check("a5_lat_e1", {31'd0, uart_tx}, 1);
    hold(1);
    check("a5_lat_e2", {31'd0, uart_tx}, 0);
    hold(FRAME - 10);
    check("a5_busy_in_stop", {31'd0, tx_busy}, 1);
    hold(12);
    check("a5_busy_done", {31'd0, tx_busy}, 0);
    wait_drain("a5");

    // Six back-to-back pushes into a 4-deep FIFO. The first byte leaves the
    // FIFO for the transmitter one cycle after it is written, so the fifth
    // consecutive push is the one that fills it.
    tx_starts.delete();
    for (int k = 0; k < 5; k++) push(8'($urandom_range(0, 255)));
    check("b2b_full", {31'd0, tx_ready}, 0);
    push(8'($urandom_range(0, 255)));
    wait_drain("b2b");
    check("b2b_frames", tx_starts.size(), 6);
    for (int k = 1; k < 6 && k < tx_starts.size(); k++)
      check("b2b_gap", tx_starts[k] - tx_starts[k-1], FRAME + 1);

    // Loopback
    loop = 1'b1;
    rx_ready = 1'b1;
    push(8'h3C);
    wait_drain("loop3c");
    for (int k = 0; k < 8; k++) push(8'($urandom_range(0, 255)));
    wait_drain("loop_rand");
    loop = 1'b0;
    hold(4);

    // Stop bit held low
    drive_rx(8'h55, 0, 0);
    check("fe_no_valid", {31'd0, rx_valid}, 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    drive_rx(8'h11, 0, 1);
    drive_rx(8'h22, 0, 1);
    check("ovr_valid_held", {31'd0, rx_valid}, 1);
    check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    begin
      ev_t e;
      e = '0;
      e.take = 1'b1;
      e.data = hold_data;
      rx_exp.push_back(e);
    end
    rx_ready = 1'b1;
    hold_full = 0;
    hold(3);
    check("ovr_consumed", {31'd0, rx_valid}, 0);
    check("ovr_events_done", rx_exp.size(), 0);

    // Parity: TX of 0x07 and injected bad parity (good byte when parity is off)
    push(8'h07);
    wait_drain("par_tx");
    drive_rx(8'h07, 1, 1);
    drive_rx(8'h5A, 1, 0);
    check("par_no_valid", {31'd0, rx_valid}, 0);

    // Start-bit glitch: no event expected
    drv_rx = 1'b0;
    hold(3);
    drv_rx = 1'b1;
    hold(3 * CPB);

    // Random RX frames with random faults
    for (int k = 0; k < 12; k++) begin
      r = 8'($urandom_range(0, 255));
      drive_rx(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    wait_drain("rx_rand");

    // Reset asserted in the middle of the data bits
    push(8'h5A);
    push(8'hC3);
    hold(2 + 3 * CPB);
    #3;
    RST_N = 1'b0;
    #1;
    check("mid_rst_tx_high", {31'd0, uart_tx}, 1);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 1);
    tx_exp.delete();
    hold(2);
    RST_N = 1'b1;
    hold(1);
    check("post_rst_tx_ready", {31'd0, tx_ready}, 1);
    check("post_rst_tx_busy", {31'd0, tx_busy}, 0);
    lows = 0;
    repeat (2 * FRAME) begin
      @(negedge CLK);
      if (uart_tx !== 1'b1) lows++;
    end
    check("no_residual_frame", lows, 0);

    // Traffic still works after the reset
    loop = 1'b1;
    push(8'h96);
    wait_drain("post_rst_loop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
